// File: rtl/dot_accumulator.sv
// Sums Len aligned multiply-add results into one dot product behind a valid/ready port.
// Define ACC_SAT_EN to saturate the accumulator and expose a sticky overflow flag.
module dot_accumulator #(
    parameter int unsigned Lat  = 3,
    parameter int unsigned Dw   = 32,
    parameter int unsigned Aw   = 40,
    parameter int unsigned CntW = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [CntW-1:0] len_i,
    input  logic            in_valid_i,
    input  logic [Dw-1:0]   c_in_i,
    output logic [Aw-1:0]   sum_o,
    output logic            sum_valid_o,
    input  logic            sum_ready_i,
    output logic            busy_o,
    output logic            ovf_o
);

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [Lat-1:0]  v_dly_q;
    logic            v_al;
    logic [Aw-1:0]   acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            start_ok;

`ifdef ACC_SAT_EN
    logic            ovf_q, ovf_d;
    logic [Aw:0]     add_full;

    assign add_full = {1'b0, acc_q} + (Aw + 1)'(c_in_i);
`endif

    // The upstream pipeline carries no valid, so its latency is mirrored here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_dly_q <= '0;
        end else begin
            v_dly_q[0] <= in_valid_i;
            for (int i = 1; i < Lat; i++) begin
                v_dly_q[i] <= v_dly_q[i-1];
            end
        end
    end

    assign v_al = v_dly_q[Lat-1];

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        start_ok = 1'b0;
`ifdef ACC_SAT_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                start_ok = start_i;
            end
            StAcc: begin
                if (v_al) begin
`ifdef ACC_SAT_EN
                    if (add_full[Aw]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = add_full[Aw-1:0];
                    end
`else
                    acc_d = acc_q + Aw'(c_in_i);
`endif
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // A Start on the handshake cycle launches the next op with no idle bubble.
                if (sum_ready_i) begin
                    state_d  = StIdle;
                    start_ok = start_i;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start_ok) begin
            acc_d   = '0;
            cnt_d   = len_i;
            state_d = (len_i == '0) ? StDone : StAcc;
`ifdef ACC_SAT_EN
            ovf_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ACC_SAT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

    assign sum_o       = acc_q;
    assign sum_valid_o = (state_q == StDone);
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_dot_accumulator.sv
// Randomized bench for dot_accumulator against a cycle-indexed behavioural model.
// Directed cases pin the model with hand-computed sums; honours ACC_SAT_EN if defined.
module tb_dot_accumulator;

    localparam int unsigned LAT  = 3;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 34;
    localparam int unsigned CNTW = 8;
    localparam int unsigned HIST = 64;

    logic            clk_i       = 1'b0;
    logic            rst_ni      = 1'b0;
    logic            start_i     = 1'b0;
    logic [CNTW-1:0] len_i       = '0;
    logic            in_valid_i  = 1'b0;
    logic [DW-1:0]   c_in_i      = '0;
    logic            sum_ready_i = 1'b0;
    logic [AW-1:0]   sum_o;
    logic            sum_valid_o;
    logic            busy_o;
    logic            ovf_o;

    dot_accumulator #(
        .Lat (LAT),
        .Dw  (DW),
        .Aw  (AW),
        .CntW(CNTW)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .len_i      (len_i),
        .in_valid_i (in_valid_i),
        .c_in_i     (c_in_i),
        .sum_o      (sum_o),
        .sum_valid_o(sum_valid_o),
        .sum_ready_i(sum_ready_i),
        .busy_o     (busy_o),
        .ovf_o      (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Model state: terms still owed, whether a result is on offer, running sum, overflow.
    int            m_cyc;
    int            m_need;
    bit            m_done;
    bit            m_ovf;
    logic [AW-1:0] m_sum;
    bit            iv_hist [HIST];

    int            n_cmp = 0;
    int            n_bad = 0;
    bit            chk_en = 1'b0;
    logic [DW-1:0] cq[$];

    always @(posedge clk_i or negedge rst_ni) begin : model
        if (!rst_ni) begin
            m_cyc  <= 0;
            m_need <= 0;
            m_done <= 1'b0;
            m_ovf  <= 1'b0;
            m_sum  <= '0;
        end else begin : upd
            bit          v_al;
            bit          launch;
            int          need;
            bit          done;
            bit          ov;
            logic [AW-1:0] s;
            logic [AW:0] w;
            // A term is aligned here if In_valid was high LAT cycles ago since reset release.
            v_al   = (m_cyc >= int'(LAT)) && iv_hist[(m_cyc - int'(LAT)) % HIST];
            launch = 1'b0;
            need   = m_need;
            done   = m_done;
            ov     = m_ovf;
            s      = m_sum;
            if (need > 0) begin
                if (v_al) begin
                    w = (AW + 1)'(s) + (AW + 1)'(c_in_i);
`ifdef ACC_SAT_EN
                    if (w[AW]) begin
                        s  = '1;
                        ov = 1'b1;
                    end else begin
                        s = w[AW-1:0];
                    end
`else
                    s = w[AW-1:0];
`endif
                    need = need - 1;
                    if (need == 0) done = 1'b1;
                end
            end else if (done) begin
                if (sum_ready_i) begin
                    done   = 1'b0;
                    launch = start_i;
                end
            end else begin
                launch = start_i;
            end
            if (launch) begin
                s  = '0;
                ov = 1'b0;
                if (len_i == '0) done = 1'b1;
                else need = int'(len_i);
            end
            iv_hist[m_cyc % HIST] <= in_valid_i;
            m_cyc  <= m_cyc + 1;
            m_need <= need;
            m_done <= done;
            m_ovf  <= ov;
            m_sum  <= s;
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            n_cmp++;
            if (sum_o !== m_sum || sum_valid_o !== m_done || ovf_o !== m_ovf ||
                busy_o !== ((m_need > 0) || m_done)) begin
                n_bad++;
                if (n_bad < 20)
                    $display("FAIL cycle_model t=%0t: got sum=%h valid=%b busy=%b ovf=%b, want sum=%h valid=%b busy=%b ovf=%b",
                             $time, sum_o, sum_valid_o, busy_o, ovf_o, m_sum, m_done,
                             (m_need > 0) || m_done, m_ovf);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; c is paired with this cycle's In_valid and appears LAT cycles later.
    task automatic step(input bit st, input logic [CNTW-1:0] ln, input bit iv,
                        input logic [DW-1:0] c, input bit rdy);
        @(negedge clk_i);
        #1;
        start_i     = st;
        len_i       = ln;
        in_valid_i  = iv;
        sum_ready_i = rdy;
        cq.push_back(c);
        c_in_i = cq.pop_front();
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (!sum_valid_o && n < 60) begin
            step(1'b0, '0, 1'b0, $urandom, 1'b0);
            n++;
        end
        check(name, 64'(sum_valid_o), 64'd1);
    endtask

    task automatic accept(input string name);
        step(1'b0, '0, 1'b0, $urandom, 1'b1);
        step(1'b0, '0, 1'b0, $urandom, 1'b0);
        check(name, 64'(busy_o), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #1;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int            n;
        logic [AW-1:0] t4_sum;
        bit            t4_ovf;
        for (int i = 0; i < int'(LAT); i++) cq.push_back('0);

        repeat (2) @(negedge clk_i);
        #1;
        check("rst_sum", 64'(sum_o), 64'd0);
        check("rst_valid", 64'(sum_valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_ovf", 64'(ovf_o), 64'd0);
        rst_ni = 1'b1;
        chk_en = 1'b1;

        // T1: three aligned terms, result held while the consumer stalls.
        step(1'b1, 8'd3, 1'b0, 0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 10, 1'b0);
        step(1'b0, 8'd0, 1'b1, 20, 1'b0);
        step(1'b0, 8'd0, 1'b1, 30, 1'b0);
        wait_done("t1_done", n);
        check("t1_latency", 64'(n), 64'(LAT + 1));
        check("t1_sum", 64'(sum_o), 64'd60);
        check("t1_model", 64'(m_sum), 64'd60);
        repeat (5) begin
            step(1'b0, '0, 1'b0, $urandom, 1'b0);
            check("t1_hold", 64'(sum_o), 64'd60);
        end
        accept("t1_idle");

        // T2: a non-aligned C value must be ignored.
        step(1'b1, 8'd2, 1'b0, 0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 5, 1'b0);
        step(1'b0, 8'd0, 1'b0, 99, 1'b0);
        step(1'b0, 8'd0, 1'b1, 7, 1'b0);
        wait_done("t2_done", n);
        check("t2_sum", 64'(sum_o), 64'd12);
        check("t2_model", 64'(m_sum), 64'd12);
        accept("t2_idle");

        // T3: zero-length op completes on the next cycle.
        step(1'b1, 8'd0, 1'b0, 0, 1'b0);
        wait_done("t3_done", n);
        check("t3_latency", 64'(n), 64'd1);
        check("t3_sum", 64'(sum_o), 64'd0);
        accept("t3_idle");

        // T4: eight all-ones terms overflow a 34-bit accumulator.
        step(1'b1, 8'd8, 1'b0, 0, 1'b0);
        repeat (8) step(1'b0, 8'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        wait_done("t4_done", n);
`ifdef ACC_SAT_EN
        t4_sum = 34'h3_FFFF_FFFF;
        t4_ovf = 1'b1;
`else
        t4_sum = 34'h3_FFFF_FFF8;
        t4_ovf = 1'b0;
`endif
        check("t4_sum", 64'(sum_o), 64'(t4_sum));
        check("t4_model", 64'(m_sum), 64'(t4_sum));
        check("t4_ovf", 64'(ovf_o), 64'(t4_ovf));
        accept("t4_idle");

        // T5: reset in the middle of an op drops everything at once.
        step(1'b1, 8'd4, 1'b0, 0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 5, 1'b0);
        step(1'b0, 8'd0, 1'b1, 6, 1'b0);
        repeat (LAT + 1) step(1'b0, '0, 1'b0, $urandom, 1'b0);
        check("t5_partial", 64'(sum_o), 64'd11);
        check("t5_busy", 64'(busy_o), 64'd1);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check("t5_rst_sum", 64'(sum_o), 64'd0);
        check("t5_rst_busy", 64'(busy_o), 64'd0);
        check("t5_rst_valid", 64'(sum_valid_o), 64'd0);
        repeat (2) @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        step(1'b1, 8'd1, 1'b0, 0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 4, 1'b0);
        wait_done("t5_done", n);
        check("t5_sum", 64'(sum_o), 64'd4);
        accept("t5_idle");

        // T6: Start ignored while accumulating, accepted on the handshake cycle.
        step(1'b1, 8'd2, 1'b0, 0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1, 1'b0);
        step(1'b1, 8'd5, 1'b0, $urandom, 1'b0);
        step(1'b0, 8'd0, 1'b1, 2, 1'b0);
        wait_done("t6_done", n);
        check("t6_sum", 64'(sum_o), 64'd3);
        step(1'b1, 8'd2, 1'b0, 0, 1'b1);
        step(1'b0, 8'd0, 1'b1, 3, 1'b0);
        check("t6_b2b_busy", 64'(busy_o), 64'd1);
        check("t6_b2b_valid", 64'(sum_valid_o), 64'd0);
        step(1'b0, 8'd0, 1'b1, 4, 1'b0);
        wait_done("t6_b2b_done", n);
        check("t6_b2b_sum", 64'(sum_o), 64'd7);
        accept("t6_idle");

        // Random traffic: starts in every state, stalls, gaps, wraps and rare resets.
        for (int k = 0; k < 3000; k++) begin
            logic [CNTW-1:0] ln;
            logic [DW-1:0]   c;
            if ($urandom_range(0, 699) == 0) do_reset();
            ln = ($urandom_range(0, 3) == 0) ? CNTW'($urandom_range(0, 20))
                                             : CNTW'($urandom_range(0, 4));
            c  = ($urandom_range(0, 7) == 0) ? '1 : DW'($urandom);
            step($urandom_range(0, 5) == 0, ln, 1'($urandom_range(0, 1)), c,
                 $urandom_range(0, 2) != 0);
        end
        step(1'b0, '0, 1'b0, 0, 1'b1);
        step(1'b0, '0, 1'b0, 0, 1'b0);
        @(negedge clk_i);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
